// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Used by regfile_wb_arbiter and wb_starve_counter.
// Contents: address/data widths, the r0 constant, the writeback request
// record and the grant encoding.
package regfile_wb_pkg;

    localparam int unsigned            REG_ADDR_W = 5;
    localparam int unsigned            DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0]  REG_ZERO   = '0;

    // One writeback request: destination register plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } wb_grant_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating starvation counter for the low-priority writeback requester.
// Counts consecutive refused cycles and raises force_a_o once the count
// reaches STARVE_LIMIT; it stays there until cleared.
// Ports:
//   clk        clock, posedge
//   rst_n      asynchronous active-low reset (count -> 0)
//   clr_i      clear the count (requester granted or idle)
//   inc_i      requester refused this cycle
//   force_a_o  count has reached STARVE_LIMIT
module wb_starve_counter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic force_a_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_a_o = (cnt_q == LIMIT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between the ALU pipe (A) and
// the load pipe (B). B has fixed priority; A is forced through after being
// refused STARVE_LIMIT consecutive cycles. The write port is registered
// (latency 1) and writes to r0 are dropped.
// Optional macro REGFILE_WB_BYPASS_EN: enables the same-cycle read bypass
// of the write in flight; otherwise the bypass outputs are tied to zero.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   a_valid/a_ready/a_reg/a_data  ALU writeback request handshake
//   b_valid/b_ready/b_reg/b_data  load writeback request handshake
//   wr_en/wr_reg/wr_data       registered register-file write port
//   rd_reg1/rd_reg2            read selects compared for bypass
//   byp_hit1/byp_hit2/byp_data bypass match flags and data
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_reg1,
    input  logic [REG_ADDR_W-1:0] rd_reg2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_W-1:0]     byp_data
);

    logic      force_a;
    wb_grant_t grant;
    wb_req_t   win;

    logic                  wr_en_q,   wr_en_d;
    logic [REG_ADDR_W-1:0] wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    wb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (~a_valid | a_ready),
        .inc_i     (a_valid & ~a_ready),
        .force_a_o (force_a)
    );

    // B wins unless A is both waiting and starved; at most one ready.
    assign b_ready = b_valid & ~(force_a & a_valid);
    assign a_ready = a_valid & (~b_valid | force_a);

    always_comb begin
        grant = GNT_NONE;
        win   = '0;
        if (b_ready) begin
            grant = GNT_B;
            win   = '{addr: b_reg, data: b_data};
        end else if (a_ready) begin
            grant = GNT_A;
            win   = '{addr: a_reg, data: a_data};
        end
    end

    // An accepted write to r0 completes the handshake but leaves the
    // write port idle with its previous select/data.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if ((grant != GNT_NONE) && (win.addr != REG_ZERO)) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = win.addr;
            wr_data_d = win.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_hit1 = wr_en_q & (rd_reg1 == wr_reg_q) & (rd_reg1 != REG_ZERO);
    assign byp_hit2 = wr_en_q & (rd_reg2 == wr_reg_q) & (rd_reg2 != REG_ZERO);
    assign byp_data = wr_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_reg1, rd_reg2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg = '0, b_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        wr_en, byp_hit1, byp_hit2;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data, byp_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
    );

    typedef struct {
        logic        a_rdy, b_rdy, en, hit1, hit2;
        logic [4:0]  wreg;
        logic [31:0] wdata, bdata;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state: what the write port should show this cycle, how many
    // cycles in a row A has been turned away, and the resulting register file.
    logic        m_en = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;
    int          streak = 0;
    logic [31:0] rf_ref [32];
    logic [31:0] rf_dut [32];
    logic        got_a, got_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("a_ready",  32'(a_ready),  32'(e.a_rdy));
            chk("b_ready",  32'(b_ready),  32'(e.b_rdy));
            chk("wr_en",    32'(wr_en),    32'(e.en));
            chk("wr_reg",   32'(wr_reg),   32'(e.wreg));
            chk("wr_data",  wr_data,       e.wdata);
            chk("byp_hit1", 32'(byp_hit1), 32'(e.hit1));
            chk("byp_hit2", 32'(byp_hit2), 32'(e.hit2));
            chk("byp_data", byp_data,      e.bdata);
        end
    end

    // Register file as the DUT's write port actually updates it.
    always @(posedge clk) begin
        if (wr_en) rf_dut[wr_reg] <= wr_data;
    end

    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        logic aw, bw;
        @(posedge clk); #1;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        rd_reg1 = r1; rd_reg2 = r2;
        // Loads have priority unless the ALU has already been refused LIMIT times.
        aw = av && (!bv || streak == LIMIT);
        bw = bv && !aw;
        e.a_rdy = aw; e.b_rdy = bw;
        e.en = m_en; e.wreg = m_reg; e.wdata = m_data;
`ifdef REGFILE_WB_BYPASS_EN
        e.hit1  = m_en && (r1 == m_reg) && (r1 != 0);
        e.hit2  = m_en && (r2 == m_reg) && (r2 != 0);
        e.bdata = m_data;
`else
        e.hit1 = 1'b0; e.hit2 = 1'b0; e.bdata = '0;
`endif
        sbq.push_back(e);
        if (m_en) rf_ref[m_reg] = m_data;
        m_en = 1'b0;
        if (bw && br != 0) begin m_en = 1'b1; m_reg = br; m_data = bd; end
        if (aw && ar != 0) begin m_en = 1'b1; m_reg = ar; m_data = ad; end
        if (av && !aw) begin
            if (streak < LIMIT) streak++;
        end else begin
            streak = 0;
        end
        got_a = aw; got_b = bw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_en",   32'(wr_en),  32'd0);
        chk("rst_wr_reg",  32'(wr_reg), 32'd0);
        chk("rst_wr_data", wr_data,     32'd0);
        m_en = 1'b0; m_reg = '0; m_data = '0; streak = 0;
        @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        logic        pa_v, pb_v;
        logic [4:0]  pa_r, pb_r, r1;
        logic [31:0] pa_d, pb_d;
        int          ai;

        for (int i = 0; i < 32; i++) begin rf_ref[i] = '0; rf_dut[i] = '0; end
        got_a = 0; got_b = 0;

        // Reset values and release.
        repeat (2) @(posedge clk);
        #1;
        chk("init_wr_en",   32'(wr_en),  32'd0);
        chk("init_wr_data", wr_data,     32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Lone ALU write.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(2);
        // Load to r0: handshake only, port holds r5/DEADBEEF.
        step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
        idle(2);
        // Bypass of the write in flight.
        step(1, 5'd7, 32'h12345678, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        idle(1);

        // Both requesting continuously: starvation rotation.
        ai = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 5'd3, 32'hA000_0000 + 32'(ai), 1, 5'd4, 32'hB000_0000 + 32'(i), 5'd3, 5'd4);
            if (got_a) ai++;
        end
        idle(1);

        // Reset while a write is in flight and A has been refused twice.
        step(1, 5'd11, 32'h1111_0001, 1, 5'd12, 32'h2222_0001, 0, 0);
        step(1, 5'd11, 32'h1111_0001, 1, 5'd12, 32'h2222_0002, 0, 0);
        mid_reset();
        step(1, 5'd6, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 5; i++)
            step(1, 5'd13, 32'h3333_0000, 1, 5'd14, 32'h4444_0000 + 32'(i), 5'd13, 0);
        idle(1);

        // Same destination from both sides: A's value must end up in r9.
        step(1, 5'd9, 32'h2, 1, 5'd9, 32'h1, 5'd9, 5'd9);
        step(1, 5'd9, 32'h2, 0, 0, 0, 5'd9, 0);
        idle(3);
        chk("r9_final", rf_dut[9], 32'h2);

        // Randomized traffic with requesters holding until accepted.
        pa_v = 0; pb_v = 0; pa_r = 0; pb_r = 0; pa_d = 0; pb_d = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pa_v && ($urandom_range(0, 3) != 0)) begin
                pa_v = 1; pa_r = 5'($urandom_range(0, 31)); pa_d = $urandom;
            end
            if (!pb_v && ($urandom_range(0, 2) != 0)) begin
                pb_v = 1; pb_r = 5'($urandom_range(0, 31)); pb_d = $urandom;
            end
            r1 = ($urandom_range(0, 1) == 0) ? m_reg : 5'($urandom_range(0, 31));
            step(pa_v, pa_r, pa_d, pb_v, pb_r, pb_d, r1, 5'($urandom_range(0, 31)));
            if (got_a) pa_v = 0;
            if (got_b) pb_v = 0;
        end
        idle(3);

        @(negedge clk); #1;
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf_dut[i], rf_ref[i]);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU pipe (port A) and the load/memory pipe (port B).
- Arbitrates with fixed priority to B plus an anti-starvation counter for A.
- Drives registered write-enable, write-register and write-data signals straight into the 32x32 register file; writes to r0 are suppressed.
- Optionally provides a same-cycle read bypass of the write in flight.

Parameters:
- STARVE_LIMIT, 3, consecutive cycles A may be refused while valid before it is forced to win; legal range 1..15.
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request accepted this cycle.
- a_reg  in  5  ALU destination register.
- a_data  in  32  ALU result.
- b_valid  in  1  load writeback request.
- b_ready  out  1  load request accepted this cycle.
- b_reg  in  5  load destination register.
- b_data  in  32  load data.
- wr_en  out  1  register-file write enable.
- wr_reg  out  5  register-file write select.
- wr_data  out  32  register-file write data.
- rd_reg1  in  5  read select 1, for bypass compare.
- rd_reg2  in  5  read select 2, for bypass compare.
- byp_hit1  out  1  read 1 matches the write in flight.
- byp_hit2  out  1  read 2 matches the write in flight.
- byp_data  out  32  bypass data.

Behaviour:
- Clock is clk; reset is asynchronous, active-low, named rst_n.
- Reset (async assert, sync release): wr_en=0, wr_reg=0, wr_data=0, starvation count=0.
  - Reset asserted mid-operation drops wr_en immediately; no pending write survives.
- Handshake: a transfer occurs when valid&ready at a posedge.
  - ready is combinational from valid and state and may depend on valid.
  - A requester holds its valid/reg/data stable until accepted.
- At most one grant per cycle:
  - force_a = (cnt == STARVE_LIMIT).
  - b_ready = b_valid & ~(force_a & a_valid).
  - a_ready = a_valid & (~b_valid | force_a).
  - Only one requester valid: that requester is granted the same cycle.
- Starvation counter (saturating):
  - Increments when a_valid & ~a_ready.
  - Clears when a_ready, or when a_valid=0.
  - Holds at STARVE_LIMIT until A is granted.
- Output register, latency 1:
  - Accept at edge T with reg != 0: wr_en=1, wr_reg/wr_data = granted reg/data during cycle T+1. The register file commits at the end of T+1.
  - Accept with reg==0: handshake completes, wr_en=0 in T+1, wr_reg/wr_data hold.
  - No accept: wr_en=0, wr_reg/wr_data hold.
  - Back-to-back accepts produce back-to-back wr_en cycles.
- Simultaneous valid with the same destination register: B is written first and A on a later cycle, so A's value persists.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - byp_hit1 = wr_en & (rd_reg1==wr_reg) & (rd_reg1!=0); byp_hit2 likewise with rd_reg2.
  - byp_data = wr_data.
  - All purely combinational from registered state.
- Undefined: byp_hit1=byp_hit2=0 and byp_data=0 constant; rd_reg1/rd_reg2 unused. Port list is identical in both builds.

Decomposition:
- Package regfile_wb_pkg:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0.
  - typedef wb_req_t {reg, data}.
  - typedef enum wb_grant_t {GNT_NONE, GNT_A, GNT_B}.
- Sub-module wb_starve_counter (parameterised saturating counter with clear/inc/force_a) is natural. Arbitration, output register and bypass stay in the top module.

Test Plan:
1. Only a_valid with a_reg=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle wr_en=1, wr_reg=5, wr_data=0xDEADBEEF; wr_en=0 the cycle after.
2. a_valid and b_valid held high, STARVE_LIMIT=3 -> b_ready on cycles 0,1,2; a_ready on cycle 3 (b_ready=0); counter reads 0 on cycle 4; pattern repeats.
3. b_valid with b_reg=0, b_data=0xFFFFFFFF -> b_ready=1; wr_en stays 0; wr_reg/wr_data unchanged.
4. With REGFILE_WB_BYPASS_EN, accept A r7=0x12345678, next cycle rd_reg1=7, rd_reg2=0 -> byp_hit1=1, byp_data=0x12345678, byp_hit2=0. Without the macro -> both hits 0.
5. rst_n pulled low mid-cycle while wr_en=1 and counter=2 -> wr_en=0 and counter=0 before the next edge; first post-reset grant follows rule 1 timing.
6. Both valid for the same register r9 (B=0x1, A=0x2), STARVE_LIMIT=1 -> wr_data 0x1 then 0x2 on consecutive write cycles.
